// File: rtl/vga_word_fetch_if.sv
// Shared-memory read port between the word fetcher (master) and memory (slave).
// No added latency; request and address are held until the memory acknowledges.
// Backpressure: memory stalls the fetcher by keeping mem_rd_ack low.
interface vga_word_fetch_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_ack;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (output mem_rd_req, output mem_rd_addr, input mem_rd_ack, input mem_rd_data);
  modport slave  (input mem_rd_req, input mem_rd_addr, output mem_rd_ack, output mem_rd_data);
endinterface

// File: rtl/vga_word_fetch.sv
// Prefetches frame-buffer words and presents the word covering pixel_x; optional VGA_FETCH_UNDERRUN_CNT_EN adds underrun_count.
// Latency: pixel_in switches on the edge where pixel_x enters a new word; a fetch starts <=2 cycles after each swap.
// Backpressure: a late memory ack cannot stall the raster; the word is replaced by 0 and underrun pulses.
module vga_word_fetch #(
  parameter int unsigned DATA_WIDTH              = 16,
  parameter int unsigned ADDR_WIDTH              = 12,
  parameter int unsigned BITS_PER_MEMORY_PIXEL_X = 2,
  parameter int unsigned BITS_PER_MEMORY_PIXEL_Y = 3,
  parameter int unsigned HEX_START_X             = 512,
  parameter int unsigned AREA_LINES              = 384,
  parameter int unsigned H_TOTAL                 = 800,
  parameter int unsigned V_TOTAL                 = 525
) (
  input  logic                  CLK_50,
  input  logic                  RESET_N,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  vga_word_fetch_if.master      mem,
  output logic [DATA_WIDTH-1:0] pixel_in,
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  output logic [15:0]           underrun_count,
`endif
  output logic                  underrun
);
  localparam int unsigned PPW    = DATA_WIDTH << BITS_PER_MEMORY_PIXEL_X;
  localparam int unsigned WPR    = HEX_START_X / PPW;
  localparam int unsigned LAST_X = (WPR - 1) * PPW;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL} state_t;
  state_t r_state, w_state_nxt;

  logic [31:0]           w_x, w_y, w_yn;
  logic [ADDR_WIDTH-1:0] w_tgt_addr;
  logic                  w_tgt_vld, w_swap, w_blank, w_ready, w_load, w_urun;
  logic [DATA_WIDTH-1:0] r_nbuf, r_pixel;
  logic [ADDR_WIDTH-1:0] r_ntag, r_addr;
  logic                  r_nvld, r_stale, r_underrun;

  always_comb begin
    w_x  = 32'(pixel_x);
    w_y  = 32'(pixel_y);
    w_yn = (w_y == V_TOTAL - 1) ? 32'd0 : w_y + 32'd1;
    if (w_x < LAST_X && w_y < AREA_LINES) begin
      w_tgt_addr = ADDR_WIDTH'((w_y >> BITS_PER_MEMORY_PIXEL_Y) * WPR + w_x / PPW + 32'd1);
      w_tgt_vld  = 1'b1;
    end else begin
      w_tgt_addr = ADDR_WIDTH'((w_yn >> BITS_PER_MEMORY_PIXEL_Y) * WPR);
      w_tgt_vld  = (w_yn < AREA_LINES);
    end
    // The target at a swap point is exactly the word that must be shown next.
    w_swap  = (w_x == H_TOTAL - 1) ||
              (w_y < AREA_LINES && w_x < LAST_X && (w_x % PPW) == PPW - 1);
    w_blank = (w_x == HEX_START_X - 1);
    w_ready = r_nvld && (r_ntag == w_tgt_addr);
    w_urun  = w_swap && w_tgt_vld && !w_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Never start a fetch on a swap cycle: that target is being consumed now.
        if (w_tgt_vld && !w_swap && (!r_nvld || r_ntag != w_tgt_addr))
          w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mem.mem_rd_ack) begin
          if (r_stale || w_swap) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_FULL;
            w_load      = 1'b1;
          end
        end
      end
      S_FULL: begin
        if (w_swap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_addr     <= '0;
      r_nbuf     <= '0;
      r_ntag     <= '0;
      r_nvld     <= 1'b0;
      r_stale    <= 1'b0;
      r_pixel    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_urun;
      if (r_state == S_IDLE && w_state_nxt == S_REQ) r_addr <= w_tgt_addr;
      if (w_load) begin
        r_nbuf <= mem.mem_rd_data;
        r_ntag <= r_addr;
        r_nvld <= 1'b1;
      end else if (r_state == S_FULL && w_swap) begin
        r_nvld <= 1'b0;
      end
      if (r_state == S_REQ) r_stale <= mem.mem_rd_ack ? 1'b0 : (r_stale || w_swap);
      if (w_swap) r_pixel <= (w_tgt_vld && w_ready) ? r_nbuf : '0;
      else if (w_blank) r_pixel <= '0;
    end
  end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [15:0] r_urun_cnt;
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) r_urun_cnt <= '0;
    else if (w_urun && r_urun_cnt != 16'hFFFF) r_urun_cnt <= r_urun_cnt + 16'd1;
  end
  assign underrun_count = r_urun_cnt;
`endif

  assign mem.mem_rd_req  = (r_state == S_REQ);
  assign mem.mem_rd_addr = r_addr;
  assign pixel_in        = r_pixel;
  assign underrun        = r_underrun;
endmodule

// File: tb/tb_vga_word_fetch.sv
// Directed bench: drives the raster, models a fixed-latency memory and scoreboards pixel_in/underrun at chosen positions.
module tb_vga_word_fetch;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    pixel_x = '0;
  logic [9:0]    pixel_y = '0;
  logic [DW-1:0] pixel_in;
  logic          underrun;
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  vga_word_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  vga_word_fetch dut (
    .CLK_50         (clk),
    .RESET_N        (rst_n),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .mem            (mif),
    .pixel_in       (pixel_in),
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    .underrun_count (underrun_count),
`endif
    .underrun       (underrun)
  );

  always #10 clk = ~clk;

  // Memory model: ack arrives lat cycles after req rises; word at address a is mem_xor ^ a.
  int            lat       = 0;
  int            mem_wait;
  logic          force_ack = 1'b0;
  logic [DW-1:0] mem_xor   = '0;

  assign mif.mem_rd_ack  = (mif.mem_rd_req && (mem_wait >= lat)) || force_ack;
  assign mif.mem_rd_data = force_ack ? 16'hDEAD : (mem_xor ^ DW'(mif.mem_rd_addr));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    mem_wait <= 0;
    else if (mif.mem_rd_req && !mif.mem_rd_ack)    mem_wait <= mem_wait + 1;
    else                                           mem_wait <= 0;
  end

  int          n_acc_blank = 0;
  int          n_acc_524   = 0;
  int          n_und       = 0;
  logic [AW-1:0] addr_524  = '1;
  always @(negedge clk) begin
    if (mif.mem_rd_req && mif.mem_rd_ack) begin
      if (pixel_y >= 10'd384 && pixel_y <= 10'd523) n_acc_blank <= n_acc_blank + 1;
      if (pixel_y == 10'd524) begin
        n_acc_524 <= n_acc_524 + 1;
        addr_524  <= mif.mem_rd_addr;
      end
    end
    if (underrun) n_und <= n_und + 1;
  end

  typedef struct { int y; int x; logic [DW-1:0] pix; logic und; } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cur_x  = 0;
  int cur_y  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_pix(input int y, input int x, input logic [DW-1:0] pix, input logic und);
    exp_t e;
    e.y = y; e.x = x; e.pix = pix; e.und = und;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cur_x == 799) begin
      cur_x = 0;
      cur_y = (cur_y == 524) ? 0 : cur_y + 1;
    end else begin
      cur_x++;
    end
    pixel_x = 10'(cur_x);
    pixel_y = 10'(cur_y);
    while (sb.size() > 0 && sb[0].x == cur_x && sb[0].y == cur_y) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("pixel_in y%0d x%0d", cur_y, cur_x), 32'(pixel_in), 32'(e.pix));
      chk($sformatf("underrun y%0d x%0d", cur_y, cur_x), 32'(underrun), 32'(e.und));
    end
  endtask

  task automatic run_to(input int y, input int x);
    int guard;
    guard = 0;
    while (!(cur_y == y && cur_x == x) && guard < 20000) begin
      step();
      guard++;
    end
    chk($sformatf("reached y%0d x%0d", y, x), 32'(cur_y * 1000 + cur_x), 32'(y * 1000 + x));
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic start_at(input int y, input int x);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    cur_x   = x;
    cur_y   = y;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    #2;
    chk("reset pixel_in", 32'(pixel_in), 32'd0);
    chk("reset mem_rd_req", 32'(mif.mem_rd_req), 32'd0);
    chk("reset mem_rd_addr", 32'(mif.mem_rd_addr), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    chk("reset underrun_count", 32'(underrun_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int und0, blank0, acc0;

    // Zero-latency memory, data = address: line 8 shows words 8..15, blank from x=512.
    lat = 0; mem_xor = '0;
    start_at(7, 0);
    und0 = n_und;
    for (int k = 0; k < 8; k++) expect_pix(8, k * 64, DW'(8 + k), 1'b0);
    expect_pix(8, 511, 16'd15, 1'b0);
    expect_pix(8, 512, 16'd0, 1'b0);
    run_to(9, 0);
    chk("no underrun at zero latency", 32'(n_und - und0), 32'd0);

    // Stray ack while FULL: buffer keeps word 9, no request is started.
    run_to(9, 10);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("no req after stray ack in FULL", 32'(mif.mem_rd_req), 32'd0);
    expect_pix(9, 64, 16'd9, 1'b0);
    run_to(9, 100);

    // Stray ack while IDLE in blanking, then frame wrap with latency 61.
    lat = 61; mem_xor = 16'hA000;
    start_at(400, 0);
    run_to(400, 5);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("no req after stray ack in IDLE", 32'(mif.mem_rd_req), 32'd0);
    cur_y = 524; cur_x = 439;
    und0 = n_und; acc0 = n_acc_524;
    for (int k = 0; k < 8; k++) expect_pix(0, k * 64, 16'hA000 ^ DW'(k), 1'b0);
    expect_pix(0, 512, 16'd0, 1'b0);
    expect_pix(1, 0, 16'hA000, 1'b0);
    expect_pix(1, 64, 16'hA001, 1'b0);
    run_to(2, 0);
    chk("no underrun at latency 61", 32'(n_und - und0), 32'd0);
    chk("one fetch during line 524", 32'(n_acc_524 - acc0), 32'd1);
    chk("line 524 fetches address 0", 32'(addr_524), 32'd0);

    // Last in-area line: no fetches once the area ends.
    lat = 0; mem_xor = '0;
    start_at(383, 0);
    blank0 = n_acc_blank;
    expect_pix(383, 448, 16'd383, 1'b0);
    expect_pix(384, 0, 16'd0, 1'b0);
    expect_pix(385, 64, 16'd0, 1'b0);
    run_to(386, 0);
    chk("no fetch on lines 384-385", 32'(n_acc_blank - blank0), 32'd0);

    // Lines 522-523 silent, line 524 prefetches word 0 for the new frame.
    lat = 61; mem_xor = 16'hA000;
    start_at(522, 0);
    blank0 = n_acc_blank; acc0 = n_acc_524; und0 = n_und;
    expect_pix(0, 0, 16'hA000, 1'b0);
    expect_pix(0, 64, 16'hA001, 1'b0);
    run_to(0, 100);
    chk("no fetch on lines 522-523", 32'(n_acc_blank - blank0), 32'd0);
    chk("wrap fetch count", 32'(n_acc_524 - acc0), 32'd1);
    chk("wrap fetch address", 32'(addr_524), 32'd0);
    chk("no underrun across wrap", 32'(n_und - und0), 32'd0);

    // Latency 62: boundary at x=127 underruns and the word for 128..191 is blank.
    lat = 62;
    start_at(524, 440);
    expect_pix(0, 0, 16'hA000, 1'b0);
    expect_pix(0, 128, 16'd0, 1'b1);
    expect_pix(0, 160, 16'd0, 1'b0);
    expect_pix(0, 191, 16'd0, 1'b0);
    run_to(0, 200);

    // Reset pulsed while a request is outstanding.
    lat = 0; mem_xor = '0;
    start_at(8, 0);
    expect_pix(8, 64, 16'd9, 1'b0);
    run_to(8, 100);
    lat = 200;
    expect_pix(8, 128, 16'd10, 1'b0);
    run_to(8, 140);
    chk("req outstanding before reset", 32'(mif.mem_rd_req), 32'd1);
    chk("req address before reset", 32'(mif.mem_rd_addr), 32'd11);
    #3;
    rst_n = 1'b0;
    #1;
    chk("req drops on async reset", 32'(mif.mem_rd_req), 32'd0);
    chk("pixel_in clears on async reset", 32'(pixel_in), 32'd0);
    lat = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_pix(8, 180, 16'd0, 1'b0);
    expect_pix(8, 192, 16'd11, 1'b0);
    run_to(8, 200);

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    // Every cycle at x=63 without a word is an underrun; the counter must saturate.
    lat = 1000000;
    start_at(0, 63);
    repeat (100) @(posedge clk);
    #1;
    chk("underrun_count after 100", 32'(underrun_count), 32'd100);
    chk("underrun held high", 32'(underrun), 32'd1);
    repeat (69900) @(posedge clk);
    #1;
    chk("underrun_count saturated", 32'(underrun_count), 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("underrun_count holds", 32'(underrun_count), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
